// File: rtl/tblink_rpc_invoke_sched.sv
// Round-robin scheduler that shares one TbLink invoke channel between N_REQ BFM requesters,
// tags each call with a unique call_id and routes responses back to their originators.
module tblink_rpc_invoke_sched #(
  parameter int N_REQ    = 4,
  parameter int METHOD_W = 8,
  parameter int PARAM_W  = 64,
  parameter int CALLID_W = 8,
  parameter int MAX_OUT  = 4
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [N_REQ-1:0]              req_valid,
  output logic [N_REQ-1:0]              req_ready,
  input  logic [N_REQ*METHOD_W-1:0]     req_method,
  input  logic [N_REQ*PARAM_W-1:0]      req_params,
  output logic                          inv_valid,
  input  logic                          inv_ready,
  output logic [METHOD_W-1:0]           inv_method,
  output logic [PARAM_W-1:0]            inv_params,
  output logic [CALLID_W-1:0]           inv_call_id,
  input  logic                          rsp_valid,
  input  logic [CALLID_W-1:0]           rsp_call_id,
  input  logic [PARAM_W-1:0]            rsp_data,
  output logic [N_REQ-1:0]              cpl_valid,
  output logic [PARAM_W-1:0]            cpl_data,
  output logic                          err_unk_id,
  output logic [$clog2(N_REQ+1)-1:0]    outstanding
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(N_REQ+1);
  localparam logic [CNT_W-1:0] MAX_OUT_C = CNT_W'(MAX_OUT);

  logic [N_REQ-1:0]    busy;
  logic [N_REQ-1:0]    issued;
  logic [CALLID_W-1:0] id_q [N_REQ];
  logic [CALLID_W-1:0] cnt_q;
  logic [PTR_W-1:0]    ptr_q;
  logic [PTR_W-1:0]    own_q;

  logic [N_REQ-1:0]    eligible;
  logic [N_REQ-1:0]    hit;
  logic [PTR_W-1:0]    win;
  logic                found;
  logic                collide;
  logic                can_load;
  logic                room;
  logic                attempt;
  logic                grant;
  int                  sidx;

  assign eligible = req_valid & ~busy;
  assign can_load = ~inv_valid | inv_ready;
  assign room     = outstanding < MAX_OUT_C;
  assign attempt  = can_load & room & (|eligible);
  assign grant    = attempt & ~collide;

  always_comb begin
    outstanding = '0;
    for (int i = 0; i < N_REQ; i++) begin
      outstanding = outstanding + CNT_W'(busy[i]);
    end
  end

  always_comb begin
    collide = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (busy[i] && (id_q[i] == cnt_q)) collide = 1'b1;
    end
  end

  // Round-robin search starting at ptr_q
  always_comb begin
    win   = '0;
    found = 1'b0;
    sidx  = 0;
    for (int k = 0; k < N_REQ; k++) begin
      sidx = int'(ptr_q) + k;
      if (sidx >= N_REQ) sidx = sidx - N_REQ;
      if (!found && eligible[sidx]) begin
        found = 1'b1;
        win   = PTR_W'(sidx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[win] = 1'b1;
  end

  // A call already completing this cycle is masked so a duplicate response reports an error.
  always_comb begin
    hit = '0;
    for (int i = 0; i < N_REQ; i++) begin
      hit[i] = rsp_valid & busy[i] & issued[i] & ~cpl_valid[i] & (id_q[i] == rsp_call_id);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy        <= '0;
      issued      <= '0;
      cnt_q       <= '0;
      ptr_q       <= '0;
      own_q       <= '0;
      inv_valid   <= 1'b0;
      inv_method  <= '0;
      inv_params  <= '0;
      inv_call_id <= '0;
      cpl_valid   <= '0;
      cpl_data    <= '0;
      err_unk_id  <= 1'b0;
      for (int i = 0; i < N_REQ; i++) id_q[i] <= '0;
    end else begin
      // Slot is released at the end of the completion cycle, usable the cycle after.
      for (int i = 0; i < N_REQ; i++) begin
        if (cpl_valid[i]) begin
          busy[i]   <= 1'b0;
          issued[i] <= 1'b0;
        end
      end

      if (inv_valid && inv_ready) issued[own_q] <= 1'b1;

      if (grant) begin
        inv_valid   <= 1'b1;
        inv_method  <= req_method[int'(win)*METHOD_W +: METHOD_W];
        inv_params  <= req_params[int'(win)*PARAM_W +: PARAM_W];
        inv_call_id <= cnt_q;
        own_q       <= win;
        busy[win]   <= 1'b1;
        id_q[win]   <= cnt_q;
        ptr_q       <= (win == PTR_W'(N_REQ-1)) ? '0 : win + 1'b1;
      end else if (inv_ready) begin
        inv_valid <= 1'b0;
      end

      if (attempt) cnt_q <= cnt_q + 1'b1;

      cpl_valid  <= hit;
      err_unk_id <= rsp_valid & ~(|hit);
      if (|hit) cpl_data <= rsp_data;
    end
  end

endmodule

// File: tb/tb_tblink_rpc_invoke_sched.sv
// Directed bench: instance a uses default parameters, instance b uses CALLID_W=2, MAX_OUT=2.
module tb_tblink_rpc_invoke_sched;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  int n_chk = 0;
  int n_fail = 0;

  // instance a
  logic [3:0]   a_req_valid, a_req_ready, a_cpl_valid;
  logic [31:0]  a_req_method;
  logic [255:0] a_req_params;
  logic         a_inv_valid, a_inv_ready, a_rsp_valid, a_err_unk_id;
  logic [7:0]   a_inv_method, a_inv_call_id, a_rsp_call_id;
  logic [63:0]  a_inv_params, a_rsp_data, a_cpl_data;
  logic [2:0]   a_outstanding;

  // instance b
  logic [3:0]   b_req_valid, b_req_ready, b_cpl_valid;
  logic [31:0]  b_req_method;
  logic [255:0] b_req_params;
  logic         b_inv_valid, b_inv_ready, b_rsp_valid, b_err_unk_id;
  logic [7:0]   b_inv_method;
  logic [1:0]   b_inv_call_id, b_rsp_call_id;
  logic [63:0]  b_inv_params, b_rsp_data, b_cpl_data;
  logic [2:0]   b_outstanding;

  tblink_rpc_invoke_sched dut_a (
    .clock(clock), .reset_n(reset_n),
    .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_method(a_req_method), .req_params(a_req_params),
    .inv_valid(a_inv_valid), .inv_ready(a_inv_ready),
    .inv_method(a_inv_method), .inv_params(a_inv_params), .inv_call_id(a_inv_call_id),
    .rsp_valid(a_rsp_valid), .rsp_call_id(a_rsp_call_id), .rsp_data(a_rsp_data),
    .cpl_valid(a_cpl_valid), .cpl_data(a_cpl_data),
    .err_unk_id(a_err_unk_id), .outstanding(a_outstanding)
  );

  tblink_rpc_invoke_sched #(.CALLID_W(2), .MAX_OUT(2)) dut_b (
    .clock(clock), .reset_n(reset_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_method(b_req_method), .req_params(b_req_params),
    .inv_valid(b_inv_valid), .inv_ready(b_inv_ready),
    .inv_method(b_inv_method), .inv_params(b_inv_params), .inv_call_id(b_inv_call_id),
    .rsp_valid(b_rsp_valid), .rsp_call_id(b_rsp_call_id), .rsp_data(b_rsp_data),
    .cpl_valid(b_cpl_valid), .cpl_data(b_cpl_data),
    .err_unk_id(b_err_unk_id), .outstanding(b_outstanding)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
  endtask

  task automatic b_call(input int r, input logic [1:0] exp_id, output int waits);
    waits = 0;
    b_req_valid = 4'(1 << r);
    #1;
    while (b_req_ready == 4'b0 && waits < 10) begin
      step(1);
      waits++;
    end
    chk("b_grant", b_req_ready, 64'(4'(1 << r)));
    step(1);
    b_req_valid = 4'b0;
    chk("b_call_id", b_inv_call_id, exp_id);
    step(1);
    b_rsp_valid = 1'b1;
    b_rsp_call_id = exp_id;
    step(1);
    b_rsp_valid = 1'b0;
    chk("b_cpl", b_cpl_valid, 64'(4'(1 << r)));
    step(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gw[8];
    int gid[8];
    int ng, ni, nerr, w, waits;
    logic pend, stable, seen;
    logic [7:0] pend_id, m0, id0;
    logic [63:0] p0;

    a_req_valid = '0; a_req_method = '0; a_req_params = '0;
    a_inv_ready = 1'b0; a_rsp_valid = 1'b0; a_rsp_call_id = '0; a_rsp_data = '0;
    b_req_valid = '0; b_req_method = '0; b_req_params = '0;
    b_inv_ready = 1'b0; b_rsp_valid = 1'b0; b_rsp_call_id = '0; b_rsp_data = '0;

    // reset state
    step(2);
    chk("rst_inv_valid", a_inv_valid, 0);
    chk("rst_outstanding", a_outstanding, 0);
    chk("rst_cpl_valid", a_cpl_valid, 0);
    chk("rst_err", a_err_unk_id, 0);
    chk("rst_call_id", a_inv_call_id, 0);
    reset_n = 1'b1;

    // single call from requester 2
    a_req_method[2*8 +: 8] = 8'h11;
    a_req_params[2*64 +: 64] = 64'hAB;
    a_req_valid = 4'b0100;
    a_inv_ready = 1'b1;
    #1;
    chk("single_ready", a_req_ready, 4'b0100);
    step(1);
    a_req_valid = '0;
    chk("single_inv_valid", a_inv_valid, 1);
    chk("single_method", a_inv_method, 8'h11);
    chk("single_params", a_inv_params, 64'hAB);
    chk("single_call_id", a_inv_call_id, 0);
    step(1);
    chk("single_inv_drop", a_inv_valid, 0);
    a_rsp_valid = 1'b1; a_rsp_call_id = 8'h00; a_rsp_data = 64'h55;
    step(1);
    a_rsp_valid = 1'b0;
    chk("single_cpl_valid", a_cpl_valid, 4'b0100);
    chk("single_cpl_data", a_cpl_data, 64'h55);
    step(1);
    chk("single_cpl_pulse", a_cpl_valid, 0);
    chk("single_outst", a_outstanding, 0);

    // fairness with immediate responses
    pulse_reset();
    for (int i = 0; i < 4; i++) a_req_method[i*8 +: 8] = 8'(8'h10 + i);
    a_req_valid = 4'b1111;
    a_inv_ready = 1'b1;
    ng = 0; ni = 0; nerr = 0; pend = 1'b0; pend_id = '0;
    for (int c = 0; c < 40 && ng < 5; c++) begin
      a_rsp_valid = pend;
      a_rsp_call_id = pend_id;
      #1;
      if (a_err_unk_id) nerr++;
      if (a_req_ready != 4'b0) begin
        w = 0;
        for (int k = 0; k < 4; k++) if (a_req_ready[k]) w = k;
        gw[ng] = w;
        ng++;
      end
      pend = a_inv_valid & a_inv_ready;
      pend_id = a_inv_call_id;
      if (pend && ni < 8) begin
        gid[ni] = int'(a_inv_call_id);
        ni++;
      end
      step(1);
    end
    a_req_valid = '0;
    a_rsp_valid = 1'b0;
    chk("fair_grants", ng, 5);
    chk("fair_order0", gw[0], 0);
    chk("fair_order1", gw[1], 1);
    chk("fair_order2", gw[2], 2);
    chk("fair_order3", gw[3], 3);
    chk("fair_order4", gw[4], 0);
    chk("fair_issued", ni, 4);
    for (int i = 0; i < 4; i++) chk("fair_id", gid[i], i);
    chk("fair_id4", a_inv_call_id, 4);
    chk("fair_id4_method", a_inv_method, 8'h10);
    chk("fair_no_err", nerr, 0);

    // backpressure, unissued response, reset mid-call
    pulse_reset();
    a_req_valid = 4'b0011;
    a_inv_ready = 1'b0;
    #1;
    chk("bp_first_grant", a_req_ready, 4'b0001);
    step(1);
    chk("bp_inv_valid", a_inv_valid, 1);
    chk("bp_call_id", a_inv_call_id, 0);
    m0 = a_inv_method; p0 = a_inv_params; id0 = a_inv_call_id;
    a_rsp_valid = 1'b1; a_rsp_call_id = 8'h00;
    step(1);
    a_rsp_valid = 1'b0;
    chk("unissued_err", a_err_unk_id, 1);
    chk("unissued_cpl", a_cpl_valid, 0);
    stable = 1'b1; seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (a_req_ready != 4'b0) seen = 1'b1;
      step(1);
      if (!a_inv_valid || a_inv_method != m0 || a_inv_params != p0 || a_inv_call_id != id0)
        stable = 1'b0;
    end
    chk("bp_stable", stable, 1);
    chk("bp_no_grant", seen, 0);
    chk("bp_outst", a_outstanding, 1);
    a_inv_ready = 1'b1;
    #1;
    chk("bp_release_grant", a_req_ready, 4'b0010);
    step(1);
    a_req_valid = '0;
    chk("bp_next_id", a_inv_call_id, 1);
    chk("bp_next_method", a_inv_method, 8'h11);
    step(1);
    chk("mid_outst_before", a_outstanding, 2);
    reset_n = 1'b0;
    #1;
    chk("mid_outst_after", a_outstanding, 0);
    chk("mid_inv_valid", a_inv_valid, 0);
    step(1);
    reset_n = 1'b1;
    a_rsp_valid = 1'b1; a_rsp_call_id = 8'h00;
    step(1);
    a_rsp_valid = 1'b0;
    chk("mid_stale_err", a_err_unk_id, 1);
    chk("mid_stale_cpl", a_cpl_valid, 0);

    // unknown id with nothing issued
    a_rsp_valid = 1'b1; a_rsp_call_id = 8'h7F;
    step(1);
    a_rsp_valid = 1'b0;
    chk("unk_err", a_err_unk_id, 1);
    step(1);
    chk("unk_err_pulse", a_err_unk_id, 0);

    // MAX_OUT=2 limit on instance b
    pulse_reset();
    b_inv_ready = 1'b1;
    b_req_valid = 4'b1111;
    ng = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (b_req_ready != 4'b0) ng++;
      step(1);
    end
    chk("lim_grants", ng, 2);
    chk("lim_outst", b_outstanding, 2);
    b_rsp_valid = 1'b1; b_rsp_call_id = 2'd0; b_rsp_data = 64'h77;
    step(1);
    b_rsp_valid = 1'b0;
    #1;
    chk("lim_cpl", b_cpl_valid, 4'b0001);
    chk("lim_cpl_data", b_cpl_data, 64'h77);
    chk("lim_no_grant_in_cpl", b_req_ready, 0);
    step(1);
    chk("lim_third_grant", b_req_ready, 4'b0100);
    step(1);
    b_req_valid = '0;
    chk("lim_third_id", b_inv_call_id, 2);
    step(1);
    b_rsp_valid = 1'b1; b_rsp_call_id = 2'd2;
    step(1);
    b_rsp_valid = 1'b0;
    chk("lim_cpl2", b_cpl_valid, 4'b0100);
    step(1);

    // id 1 still busy on requester 1: counter 3 -> 0 -> skip 1 -> 2
    b_call(0, 2'd3, waits);
    chk("wrap_wait3", waits, 0);
    b_call(0, 2'd0, waits);
    chk("wrap_wait0", waits, 0);
    b_call(0, 2'd2, waits);
    chk("skip_wait", waits, 1);
    chk("skip_outst", b_outstanding, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
